// File: rtl/lalu_pkg.sv
// Shared types for the memory arbiter: read-owner tags, bus widths and the
// granted-request bundle that drives the memory port.
package lalu_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_FETCH = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // A flush retires fetch ownership; data ownership passes through untouched.
    function automatic owner_t scrub_fetch(owner_t tag, logic flush);
        return (flush && tag == OWN_FETCH) ? OWN_NONE : tag;
    endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch, data and memory-port signals of the arbiter. master = requesters and
// memory (the environment), slave = the arbiter itself.
interface mem_arbiter_if;
    import lalu_pkg::*;

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_flush;
    logic              f_gnt;
    logic              f_valid;
    logic [DATA_W-1:0] f_data;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_gnt;
    logic              d_valid;
    logic [DATA_W-1:0] d_rdata;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport master (
        output f_req, f_addr, f_flush, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  f_gnt, f_valid, f_data, d_gnt, d_valid, d_rdata,
               m_en, m_we, m_addr, m_wdata
    );

    modport slave (
        input  f_req, f_addr, f_flush, d_req, d_we, d_addr, d_wdata, m_rdata,
        output f_gnt, f_valid, f_data, d_gnt, d_valid, d_rdata,
               m_en, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/mem_arbiter_tag_pipe.sv
// Owner-tag delay line matching the memory read latency; the tail names who
// owns m_rdata this cycle. Flush scrubs fetch tags in every stage and the tail.
module tag_pipe
    import lalu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic   clk,
    input  logic   rst,
    input  owner_t push_tag,
    input  logic   flush,
    output owner_t tail_tag
);
    owner_t tag_q [DEPTH];
    owner_t tag_d [DEPTH];

    always_comb begin
        tag_d[0] = scrub_fetch(push_tag, flush);
        for (int i = 1; i < DEPTH; i++)
            tag_d[i] = scrub_fetch(tag_q[i-1], flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= OWN_NONE;
        end else begin
            for (int i = 0; i < DEPTH; i++) tag_q[i] <= tag_d[i];
        end
    end

    assign tail_tag = scrub_fetch(tag_q[DEPTH-1], flush);
endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access:
// data-first priority with a starvation escape for fetch, tagged read returns.
module mem_arbiter
    import lalu_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic          CLOCK_50,
    input logic          RESET,
    mem_arbiter_if.slave bus
);
    logic [3:0] starve_q, starve_d;
    logic       f_ok, d_ok, fetch_first;
    logic       f_gnt, d_gnt;
    owner_t     push_tag, tail_tag;
    mem_req_t   req;

    always_comb begin
        f_ok        = bus.f_req & ~bus.f_flush & ~RESET;
        d_ok        = bus.d_req & ~RESET;
        fetch_first = (starve_q == 4'(STARVE_LIMIT));
        f_gnt       = f_ok & (~d_ok | fetch_first);
        d_gnt       = d_ok & ~f_gnt;

        req = '0;
        if (f_gnt)
            req.addr = bus.f_addr;
        else if (d_gnt)
            req = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata};

        push_tag = OWN_NONE;
        if (f_gnt)
            push_tag = OWN_FETCH;
        else if (d_gnt && !bus.d_we)
            push_tag = OWN_DATA;

        // A flushed cycle neither counts as starvation nor forgives it.
        starve_d = starve_q;
        if (!bus.f_flush)
            starve_d = (bus.f_req && !f_gnt) ? starve_q + 4'd1 : 4'd0;
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) starve_q <= 4'd0;
        else       starve_q <= starve_d;
    end

    tag_pipe #(.DEPTH(READ_LATENCY)) u_tag_pipe (
        .clk      (CLOCK_50),
        .rst      (RESET),
        .push_tag (push_tag),
        .flush    (bus.f_flush),
        .tail_tag (tail_tag)
    );

    assign bus.f_gnt   = f_gnt;
    assign bus.d_gnt   = d_gnt;
    assign bus.m_en    = f_gnt | d_gnt;
    assign bus.m_we    = req.we;
    assign bus.m_addr  = req.addr;
    assign bus.m_wdata = req.wdata;
    assign bus.f_valid = (tail_tag == OWN_FETCH);
    assign bus.d_valid = (tail_tag == OWN_DATA);
    assign bus.f_data  = bus.f_valid ? bus.m_rdata : '0;
    assign bus.d_rdata = bus.d_valid ? bus.m_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: memory environment, transaction-level model checked
// every cycle, and directed scenarios with literal expectations.
module tb_mem_arbiter;
    import lalu_pkg::*;

    parameter int READ_LATENCY = 2;
    localparam int STARVE_LIMIT = 4;
    localparam logic [31:0] JUNK = 32'h0BAD0BAD;

    logic clk = 1'b0;
    logic rst;
    mem_arbiter_if bus();

    mem_arbiter #(.READ_LATENCY(READ_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic logic [31:0] seed(input logic [15:0] a);
        return {16'hC0DE, a};
    endfunction

    // ---------------- memory environment ----------------
    logic [31:0] env_mem [0:65535];
    bit          env_wr  [0:65535];
    logic [31:0] rd_line [READ_LATENCY];
    logic        cap_rd, cap_wr;
    logic [15:0] cap_a;
    logic [31:0] cap_wd;

    always @(negedge clk) begin
        cap_rd = bus.m_en && !bus.m_we;
        cap_wr = bus.m_en && bus.m_we;
        cap_a  = bus.m_addr;
        cap_wd = bus.m_wdata;
    end

    always @(posedge clk) begin
        for (int i = READ_LATENCY - 1; i > 0; i--) rd_line[i] <= rd_line[i-1];
        rd_line[0] <= cap_rd ? (env_wr[cap_a] ? env_mem[cap_a] : seed(cap_a)) : JUNK;
        if (cap_wr) begin
            env_mem[cap_a] <= cap_wd;
            env_wr[cap_a]  <= 1'b1;
        end
    end

    assign bus.m_rdata = rd_line[READ_LATENCY-1];

    // ---------------- transaction-level model ----------------
    typedef struct {
        int          due;
        int          own;   // 1 = fetch, 2 = data
        logic [31:0] data;
    } ent_t;

    ent_t        pend[$];
    logic [31:0] mdl_mem [0:65535];
    bit          mdl_wr  [0:65535];
    int          mc = 0;
    int          sc = 0;
    bit          ef, ed, tf, td;
    logic [31:0] tdat;
    logic [15:0] ea;

    always @(negedge clk) begin
        mc++;
        if (rst) begin
            pend.delete();
            sc = 0;
            chk("reset_ctrl", 32'({bus.f_gnt, bus.d_gnt, bus.m_en, bus.m_we, bus.f_valid, bus.d_valid}), 0);
            chk("reset_addr", 32'(bus.m_addr), 0);
            chk("reset_data", bus.f_data | bus.d_rdata | bus.m_wdata, 0);
        end else begin
            if (bus.f_flush)
                for (int i = pend.size() - 1; i >= 0; i--)
                    if (pend[i].own == 1) pend.delete(i);
            tf = 0; td = 0; tdat = 0;
            foreach (pend[i])
                if (pend[i].due == mc) begin
                    tf = (pend[i].own == 1);
                    td = (pend[i].own == 2);
                    tdat = pend[i].data;
                end
            ef = bus.f_req && !bus.f_flush && (!bus.d_req || sc == STARVE_LIMIT);
            ed = bus.d_req && !ef;
            ea = ef ? bus.f_addr : (ed ? bus.d_addr : 16'h0000);

            chk("f_gnt", 32'(bus.f_gnt), 32'(ef));
            chk("d_gnt", 32'(bus.d_gnt), 32'(ed));
            chk("m_en", 32'(bus.m_en), 32'(ef || ed));
            chk("m_we", 32'(bus.m_we), 32'(ed && bus.d_we));
            chk("m_addr", 32'(bus.m_addr), 32'(ea));
            if (ed && bus.d_we) chk("m_wdata", bus.m_wdata, bus.d_wdata);
            chk("f_valid", 32'(bus.f_valid), 32'(tf));
            chk("d_valid", 32'(bus.d_valid), 32'(td));
            if (tf) chk("f_data", bus.f_data, tdat);
            if (td) chk("d_rdata", bus.d_rdata, tdat);

            while (pend.size() > 0 && pend[0].due <= mc) void'(pend.pop_front());
            if (ef)
                pend.push_back('{mc + READ_LATENCY, 1,
                                 mdl_wr[bus.f_addr] ? mdl_mem[bus.f_addr] : seed(bus.f_addr)});
            if (ed && !bus.d_we)
                pend.push_back('{mc + READ_LATENCY, 2,
                                 mdl_wr[bus.d_addr] ? mdl_mem[bus.d_addr] : seed(bus.d_addr)});
            if (ed && bus.d_we) begin
                mdl_mem[bus.d_addr] = bus.d_wdata;
                mdl_wr[bus.d_addr]  = 1'b1;
            end
            if (!bus.f_flush) sc = (!bus.f_req || ef) ? 0 : sc + 1;
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        bus.f_req = 0; bus.f_addr = '0; bus.f_flush = 0;
        bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    task automatic nxt();
        @(posedge clk); #1;
    endtask

    bit fpend, dpend;

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Four consecutive fetches from reset release.
        for (int k = 0; k < 4 + READ_LATENCY; k++) begin
            bus.f_req  = (k < 4);
            bus.f_addr = 16'(k);
            @(negedge clk);
            if (k < 4) chk("t1_f_gnt", 32'(bus.f_gnt), 1);
            if (k >= READ_LATENCY) begin
                chk("t1_f_valid", 32'(bus.f_valid), 1);
                chk("t1_f_data", bus.f_data, 32'hC0DE0000 + 32'(k - READ_LATENCY));
            end else begin
                chk("t1_f_valid_early", 32'(bus.f_valid), 0);
            end
            nxt();
        end

        // Contention: data wins four times, then starvation forces fetch.
        for (int k = 0; k < 10; k++) begin
            bus.f_req = 1; bus.f_addr = 16'h0010;
            bus.d_req = 1; bus.d_we = 0; bus.d_addr = 16'h1000;
            @(negedge clk);
            chk("t2_f_gnt", 32'(bus.f_gnt), 32'(k % 5 == 4));
            chk("t2_d_gnt", 32'(bus.d_gnt), 32'(k % 5 != 4));
            nxt();
        end
        idle();
        repeat (READ_LATENCY + 1) nxt();

        // Flush one cycle after two fetches; a later fetch returns normally.
        for (int k = 0; k < 4 + READ_LATENCY; k++) begin
            bus.f_req   = (k <= 3);
            bus.f_addr  = (k < 2) ? 16'(16'h0020 + k) : 16'h0022;
            bus.f_flush = (k == 2);
            @(negedge clk);
            if (k == 2) begin
                chk("t3_flush_f_gnt", 32'(bus.f_gnt), 0);
                chk("t3_flush_f_valid", 32'(bus.f_valid), 0);
            end
            if (k >= 3 && k < 3 + READ_LATENCY) chk("t3_no_stale", 32'(bus.f_valid), 0);
            if (k == 3 + READ_LATENCY) begin
                chk("t3_refetch_valid", 32'(bus.f_valid), 1);
                chk("t3_refetch_data", bus.f_data, 32'hC0DE0022);
            end
            nxt();
        end
        idle();

        // Write then read back the same address.
        for (int k = 0; k < 2 + READ_LATENCY; k++) begin
            bus.d_req   = (k < 2);
            bus.d_we    = (k == 0);
            bus.d_addr  = 16'h2000;
            bus.d_wdata = 32'hDEADBEEF;
            @(negedge clk);
            if (k == 0) chk("t4_write_m_we", 32'(bus.m_we), 1);
            if (k == 1) chk("t4_read_m_we", 32'(bus.m_we), 0);
            if (k == READ_LATENCY) chk("t4_no_write_valid", 32'(bus.d_valid), 0);
            if (k == 1 + READ_LATENCY) begin
                chk("t4_d_valid", 32'(bus.d_valid), 1);
                chk("t4_d_rdata", bus.d_rdata, 32'hDEADBEEF);
            end
            nxt();
        end
        idle();

        // Reset with a data read in flight.
        bus.d_req = 1; bus.d_addr = 16'h3000;
        nxt();
        idle();
        rst = 1'b1;
        repeat (2) nxt();
        rst = 1'b0;
        for (int k = 0; k < 4 + READ_LATENCY; k++) begin
            @(negedge clk);
            chk("t5_d_valid", 32'(bus.d_valid), 0);
            nxt();
        end

        // Mixed traffic with random flushes; requesters hold until granted.
        fpend = 0; dpend = 0;
        for (int k = 0; k < 120; k++) begin
            if (!fpend && $urandom_range(2) == 0) begin
                fpend = 1; bus.f_addr = 16'($urandom);
            end
            if (!dpend && $urandom_range(2) != 0) begin
                dpend = 1;
                bus.d_we    = $urandom_range(1) == 1;
                bus.d_addr  = 16'(16'h2000 + $urandom_range(7));
                bus.d_wdata = $urandom;
            end
            bus.f_req   = fpend;
            bus.d_req   = dpend;
            bus.f_flush = ($urandom_range(7) == 0);
            @(negedge clk);
            if (bus.f_gnt) fpend = 0;
            if (bus.d_gnt) dpend = 0;
            nxt();
        end
        idle();
        repeat (READ_LATENCY + 2) nxt();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
